tlb_dma_arbiter: RTL and testbench

TLB_DMA_ARBITER -- requirements
Module: tlb_dma_arbiter

---
 rtl/tlb_dma_arbiter.sv | 105 ++++++++++
 tb/tb_tlb_dma_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_dma_arbiter.sv
// rtl/tlb_dma_arbiter.sv - round-robin merge of per-region DMA requests with in-order completion routing
module tlb_dma_arbiter #(
  parameter int N_REGIONS   = 4,
  parameter int ADDR_BITS   = 64,
  parameter int LEN_BITS    = 28,
  parameter int OUTST_DEPTH = 16,
  localparam int VB = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1,
  localparam int CW = $clog2(OUTST_DEPTH) + 1
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [N_REGIONS-1:0]           s_req_valid,
  output logic [N_REGIONS-1:0]           s_req_ready,
  input  logic [N_REGIONS*ADDR_BITS-1:0] s_req_paddr,
  input  logic [N_REGIONS*LEN_BITS-1:0]  s_req_len,
  input  logic [N_REGIONS-1:0]           s_req_last,
  output logic                           m_req_valid,
  input  logic                           m_req_ready,
  output logic [ADDR_BITS-1:0]           m_req_paddr,
  output logic [LEN_BITS-1:0]            m_req_len,
  output logic                           m_req_last,
  output logic [VB-1:0]                  m_req_vfid,
  input  logic                           s_done_valid,
  output logic [N_REGIONS-1:0]           m_done,
  output logic [CW-1:0]                  outstanding,
  output logic                           err_underflow
);

  localparam int PW = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;

  logic [VB-1:0] rr_ptr;
  logic [VB-1:0] gnt_idx;
  logic [VB-1:0] cand;
  logic          gnt_found;
  logic          can_grant;
  logic          grant;
  logic          pop;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [VB-1:0] fifo_mem [OUTST_DEPTH];

  // Search starts at rr_ptr, the region after the most recent grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      cand = VB'((int'(rr_ptr) + i) % N_REGIONS);
      if (!gnt_found && s_req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // The registered count is used, so a pop in this cycle cannot open a slot until the next.
  assign can_grant = aresetn && (!m_req_valid || m_req_ready) &&
                     (outstanding < CW'(OUTST_DEPTH));
  assign grant     = can_grant && gnt_found;
  assign pop       = s_done_valid && (outstanding != '0);

  always_comb begin
    s_req_ready = '0;
    if (grant) s_req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_req_valid   <= 1'b0;
      m_req_paddr   <= '0;
      m_req_len     <= '0;
      m_req_last    <= 1'b0;
      m_req_vfid    <= '0;
      rr_ptr        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      outstanding   <= '0;
      m_done        <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (grant) begin
        m_req_valid <= 1'b1;
        m_req_paddr <= s_req_paddr[gnt_idx*ADDR_BITS +: ADDR_BITS];
        m_req_len   <= s_req_len[gnt_idx*LEN_BITS +: LEN_BITS];
        m_req_last  <= s_req_last[gnt_idx];
        m_req_vfid  <= gnt_idx;
        rr_ptr      <= (gnt_idx == VB'(N_REGIONS - 1)) ? '0 : gnt_idx + 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end else if (m_req_ready) begin
        m_req_valid <= 1'b0;
      end

      if (pop) rd_ptr <= rd_ptr + 1'b1;
      outstanding <= outstanding + CW'(grant) - CW'(pop);
      m_done      <= pop ? (N_REGIONS'(1) << fifo_mem[rd_ptr]) : '0;
      if (s_done_valid && (outstanding == '0)) err_underflow <= 1'b1;
    end
  end

  // Source-region FIFO storage needs no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge aclk) begin
    if (grant) fifo_mem[wr_ptr] <= gnt_idx;
  end

endmodule

// File: tb/tb_tlb_dma_arbiter.sv
// tb/tb_tlb_dma_arbiter.sv - randomized bench with queue-based reference model for tlb_dma_arbiter
module tb_tlb_dma_arbiter;
  localparam int N  = 4;
  localparam int AB = 64;
  localparam int LB = 28;
  localparam int D  = 16;
  localparam int VB = 2;
  localparam int CW = 5;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [N-1:0]    s_req_valid = '0;
  logic [N-1:0]    s_req_ready;
  logic [N*AB-1:0] s_req_paddr = '0;
  logic [N*LB-1:0] s_req_len = '0;
  logic [N-1:0]    s_req_last = '0;
  logic            m_req_valid;
  logic            m_req_ready = 1'b0;
  logic [AB-1:0]   m_req_paddr;
  logic [LB-1:0]   m_req_len;
  logic            m_req_last;
  logic [VB-1:0]   m_req_vfid;
  logic            s_done_valid = 1'b0;
  logic [N-1:0]    m_done;
  logic [CW-1:0]   outstanding;
  logic            err_underflow;

  always #5 aclk = ~aclk;

  tlb_dma_arbiter #(.N_REGIONS(N), .ADDR_BITS(AB), .LEN_BITS(LB), .OUTST_DEPTH(D)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_paddr(s_req_paddr), .s_req_len(s_req_len), .s_req_last(s_req_last),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_paddr(m_req_paddr), .m_req_len(m_req_len), .m_req_last(m_req_last),
    .m_req_vfid(m_req_vfid), .s_done_valid(s_done_valid), .m_done(m_done),
    .outstanding(outstanding), .err_underflow(err_underflow)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pending output slot, queue of outstanding source regions, last grant.
  bit            mv;
  logic [AB-1:0] mp;
  logic [LB-1:0] ml;
  bit            mlast;
  int            mvf;
  int            q[$];
  int            last_gnt;
  logic [N-1:0]  mdone;
  bit            merr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mv = 0; mp = '0; ml = '0; mlast = 0; mvf = 0;
    q.delete();
    last_gnt = N - 1;
    mdone = '0;
    merr = 0;
  endtask

  // Called just after a falling edge with inputs already applied; returns at the next falling edge.
  task automatic cycle();
    int gnt;
    int r;
    logic [N-1:0] er;
    logic [N-1:0] nd;
    #1;
    gnt = -1;
    if ((!mv || m_req_ready) && q.size() < D) begin
      for (int k = 1; k <= N; k++) begin
        r = (last_gnt + k) % N;
        if (gnt < 0 && s_req_valid[r]) gnt = r;
      end
    end
    er = '0;
    if (gnt >= 0) er[gnt] = 1'b1;
    chk("s_req_ready", 64'(s_req_ready), 64'(er));
    chk("m_req_valid", 64'(m_req_valid), 64'(mv));
    if (mv) begin
      chk("m_req_paddr", m_req_paddr, mp);
      chk("m_req_len", 64'(m_req_len), 64'(ml));
      chk("m_req_last", 64'(m_req_last), 64'(mlast));
      chk("m_req_vfid", 64'(m_req_vfid), 64'(mvf));
    end
    chk("m_done", 64'(m_done), 64'(mdone));
    chk("outstanding", 64'(outstanding), 64'(q.size()));
    chk("err_underflow", 64'(err_underflow), 64'(merr));

    nd = '0;
    if (s_done_valid) begin
      if (q.size() > 0) begin
        nd[q[0]] = 1'b1;
        void'(q.pop_front());
      end else begin
        merr = 1;
      end
    end
    if (gnt >= 0) begin
      q.push_back(gnt);
      mv = 1;
      mp = s_req_paddr[gnt*AB +: AB];
      ml = s_req_len[gnt*LB +: LB];
      mlast = s_req_last[gnt];
      mvf = gnt;
      last_gnt = gnt;
    end else if (m_req_ready) begin
      mv = 0;
    end
    mdone = nd;
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    s_req_valid = '1;
    s_done_valid = 1'b1;
    #1;
    chk("rst_s_req_ready", 64'(s_req_ready), 64'h0);
    chk("rst_m_req_valid", 64'(m_req_valid), 64'h0);
    chk("rst_m_req_paddr", m_req_paddr, 64'h0);
    chk("rst_m_req_len", 64'(m_req_len), 64'h0);
    chk("rst_m_req_last", 64'(m_req_last), 64'h0);
    chk("rst_m_req_vfid", 64'(m_req_vfid), 64'h0);
    chk("rst_m_done", 64'(m_done), 64'h0);
    chk("rst_outstanding", 64'(outstanding), 64'h0);
    chk("rst_err_underflow", 64'(err_underflow), 64'h0);
    model_reset();
    @(posedge aclk);
    @(negedge aclk);
    chk("rst_hold_m_req_valid", 64'(m_req_valid), 64'h0);
    chk("rst_hold_m_done", 64'(m_done), 64'h0);
    aresetn = 1'b1;
    s_req_valid = '0;
    s_done_valid = 1'b0;
  endtask

  task automatic rand_fields();
    for (int r = 0; r < N; r++) begin
      s_req_paddr[r*AB +: AB] = {$urandom, $urandom};
      s_req_len[r*LB +: LB] = LB'($urandom);
      s_req_last[r] = 1'($urandom);
    end
  endtask

  initial begin
    model_reset();
    @(negedge aclk);
    do_reset();

    // Four regions always valid: vfid 0,1,2,3,0,... one per cycle, first valid one cycle after grant.
    rand_fields();
    s_req_valid = 4'hF;
    m_req_ready = 1'b1;
    #1;
    chk("rr_first_ready", 64'(s_req_ready), 64'h1);
    chk("rr_first_valid_low", 64'(m_req_valid), 64'h0);
    cycle();
    for (int k = 0; k < 8; k++) begin
      chk("rr_valid", 64'(m_req_valid), 64'h1);
      chk("rr_vfid", 64'(m_req_vfid), 64'(k % 4));
      cycle();
    end

    // Backpressure: region 2 held while m_req_ready is low.
    s_req_valid = '0;
    do_reset();
    s_req_paddr[2*AB +: AB] = 64'h1000;
    s_req_len[2*LB +: LB] = 28'd64;
    s_req_valid = 4'b0100;
    m_req_ready = 1'b0;
    cycle();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_valid", 64'(m_req_valid), 64'h1);
      chk("bp_paddr", m_req_paddr, 64'h1000);
      chk("bp_len", 64'(m_req_len), 64'd64);
      chk("bp_no_grant", 64'(s_req_ready), 64'h0);
      cycle();
    end
    m_req_ready = 1'b1;
    s_req_valid = '0;
    cycle();

    // Full FIFO: 16 grants, then a completion frees one slot for the following cycle.
    do_reset();
    s_req_valid = 4'hF;
    m_req_ready = 1'b1;
    repeat (16) cycle();
    chk("full_outstanding", 64'(outstanding), 64'd16);
    #1;
    chk("full_no_ready", 64'(s_req_ready), 64'h0);
    s_done_valid = 1'b1;
    cycle();
    s_done_valid = 1'b0;
    chk("full_done_region", 64'(m_done), 64'h1);
    chk("full_after_pop", 64'(outstanding), 64'd15);
    #1;
    chk("full_resume_ready", 64'(s_req_ready), 64'h1);
    cycle();

    // Simultaneous push and pop at outstanding=5.
    s_req_valid = '0;
    do_reset();
    s_req_valid = 4'hF;
    m_req_ready = 1'b1;
    repeat (5) cycle();
    chk("pp_before", 64'(outstanding), 64'd5);
    s_done_valid = 1'b1;
    cycle();
    s_done_valid = 1'b0;
    chk("pp_outstanding", 64'(outstanding), 64'd5);
    chk("pp_done_head", 64'(m_done), 64'h1);

    // Underflow is sticky until reset.
    s_req_valid = '0;
    do_reset();
    s_done_valid = 1'b1;
    cycle();
    s_done_valid = 1'b0;
    chk("uf_no_done", 64'(m_done), 64'h0);
    chk("uf_err", 64'(err_underflow), 64'h1);
    repeat (3) cycle();
    chk("uf_sticky", 64'(err_underflow), 64'h1);

    // Reset mid-operation drops the output register and all outstanding entries.
    do_reset();
    s_req_valid = 4'hF;
    m_req_ready = 1'b1;
    repeat (3) cycle();
    chk("mid_outstanding", 64'(outstanding), 64'd3);
    chk("mid_valid", 64'(m_req_valid), 64'h1);
    s_req_valid = '0;
    do_reset();
    repeat (6) begin
      cycle();
      chk("mid_no_done", 64'(m_done), 64'h0);
    end

    // Randomized traffic against the model.
    for (int it = 0; it < 6000; it++) begin
      rand_fields();
      s_req_valid = ($urandom % 3 == 0) ? 4'hF : 4'($urandom);
      m_req_ready = ($urandom % 4) != 0;
      if ((it / 1000) % 2 == 1) s_done_valid = ($urandom % 2) == 0;
      else s_done_valid = ($urandom % 6) == 0;
      if ($urandom % 700 == 0) do_reset();
      else cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
